// File: rtl/bus_xfer_issuer.sv
// Register-transfer issuer: queues {src,dst} commands, drives the bus source select
// for a settle window, then pulses one destination load enable.
module bus_xfer_issuer #(
  parameter int DEPTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [4:0]  cmd_src,
  input  logic [4:0]  cmd_dst,
  output logic [4:0]  bus_sel,
  output logic        bus_sel_valid,
  output logic [23:0] dst_in,
  output logic        busy,
  output logic        err_pulse,
  output logic [15:0] xfer_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, LATCH} state_t;

  state_t        r_state;
  logic [4:0]    r_mem_src [DEPTH];
  logic [4:0]    r_mem_dst [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic [CW-1:0] r_cnt;
  logic [4:0]    r_cur_dst;
  logic [4:0]    r_bus_sel;
  logic          r_bus_sel_valid;
  logic [23:0]   r_dst_in;
  logic          r_err;
  logic [15:0]   r_xfer_count;

  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;
  logic [4:0] w_head_src;
  logic [4:0] w_head_dst;
  logic       w_head_ok;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign w_empty    = (r_wptr == r_rptr);
  assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push     = cmd_valid & ~w_full;
  assign w_pop      = ~w_empty & ((r_state == IDLE) | (r_state == LATCH));
  assign w_head_src = r_mem_src[r_rptr[AW-1:0]];
  assign w_head_dst = r_mem_dst[r_rptr[AW-1:0]];
  assign w_head_ok  = (w_head_src <= 5'd23) && (w_head_dst <= 5'd23);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_src[r_wptr[AW-1:0]] <= cmd_src;
      r_mem_dst[r_wptr[AW-1:0]] <= cmd_dst;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_cur_dst       <= '0;
      r_bus_sel       <= '0;
      r_bus_sel_valid <= 1'b0;
      r_dst_in        <= '0;
      r_err           <= 1'b0;
      r_xfer_count    <= '0;
    end else begin
      r_err    <= 1'b0;
      r_dst_in <= '0;
      case (r_state)
        IDLE, LATCH: begin
          if (r_state == LATCH) r_xfer_count <= r_xfer_count + 16'd1;
          // LATCH shares IDLE's pop path so back-to-back transfers lose no cycle.
          if (w_pop && w_head_ok) begin
            r_state         <= DRIVE;
            r_cnt           <= CNT_LOAD;
            r_cur_dst       <= w_head_dst;
            r_bus_sel       <= w_head_src;
            r_bus_sel_valid <= 1'b1;
          end else begin
            r_state         <= IDLE;
            r_bus_sel       <= '0;
            r_bus_sel_valid <= 1'b0;
            if (w_pop) r_err <= 1'b1;
          end
        end
        DRIVE: begin
          if (r_cnt == '0) begin
            r_state  <= LATCH;
            r_dst_in <= 24'd1 << r_cur_dst;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state         <= IDLE;
          r_bus_sel       <= '0;
          r_bus_sel_valid <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready     = ~w_full;
  assign busy          = ~w_empty | (r_state != IDLE);
  assign bus_sel       = r_bus_sel;
  assign bus_sel_valid = r_bus_sel_valid;
  assign dst_in        = r_dst_in;
  assign err_pulse     = r_err;
  assign xfer_count    = r_xfer_count;

endmodule

// File: doc/bus_xfer_issuer.md
Name: bus_xfer_issuer

Overview:
- Destination-side companion to the datapath bus source encoder/multiplexer.
- Accepts queued register-transfer commands {source, destination} over a valid/ready handshake.
- For each command, drives the 5-bit bus source-select code to the bus multiplexer, holds it for a settle window, then pulses exactly one destination load-enable so the target register captures the bus.
- Sits between the control unit and the datapath registers.

Parameters:
- DEPTH, 2, command FIFO entries (power of two, ≥2).
- SETTLE, 1, cycles bus_sel is driven before the load strobe (≥1).

Ports:
- clk  input  1  system clock, rising edge
- clr  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept a command
- cmd_src  input  5  source code: 0–15 R0–R15, 16 HI, 17 LO, 18 ZHigh, 19 ZLow, 20 PC, 21 MDR, 22 InPort, 23 C
- cmd_dst  input  5  destination code: 0–15 R0–R15, 16 HI, 17 LO, 18 PC, 19 MDR, 20 MAR, 21 IR, 22 Y, 23 OutPort
- bus_sel  output  5  source-select code to bus multiplexer
- bus_sel_valid  output  1  bus_sel is meaningful
- dst_in  output  24  one-hot destination load enable; bit i = dst code i
- busy  output  1  FIFO non-empty or FSM not IDLE
- err_pulse  output  1  one-cycle pulse: dropped command with invalid code
- xfer_count  output  16  completed transfers, wraps 0xFFFF→0x0000

Behaviour:
- Reset (clr=1, async): FIFO empty, state IDLE, bus_sel=0, bus_sel_valid=0, dst_in=0, err_pulse=0, xfer_count=0, busy=0, cmd_ready=1. Reset mid-transfer aborts it with no dst_in strobe.
- Push: on an edge with cmd_valid & cmd_ready. cmd_ready = !full, independent of cmd_valid. There is no bypass; a command always passes through the FIFO.
- FSM states IDLE, DRIVE, LATCH. All outputs are registered or decoded from registered state only.
- IDLE: if FIFO non-empty, pop into cur_src/cur_dst.
  - Valid codes (both ≤23): next state DRIVE.
  - Either code ≥24: entry is discarded, err_pulse=1 the next cycle, state stays IDLE.
- DRIVE: bus_sel=cur_src, bus_sel_valid=1, dst_in=0. Lasts SETTLE cycles (internal counter), then goes to LATCH.
- LATCH (exactly 1 cycle): bus_sel=cur_src, bus_sel_valid=1, dst_in = 1<<cur_dst. xfer_count increments at the end of the cycle.
  - If FIFO non-empty, pop at the same edge and go to DRIVE (valid entry) or IDLE with err_pulse (invalid entry).
  - Otherwise go to IDLE.
- IDLE/other: bus_sel=0, bus_sel_valid=0, dst_in=0.
- Latency (SETTLE=1, empty FIFO, IDLE):
  - handshake in cycle N
  - pop at edge into N+2
  - DRIVE in cycle N+2
  - dst_in strobe in cycle N+3
- Throughput back-to-back: one transfer per SETTLE+1 cycles.
- Simultaneous push and pop: allowed whenever not full. Count is unchanged and FIFO order is preserved. When full, cmd_ready=0 even if a pop occurs that cycle.
- Pointer wrap: read and write pointers wrap modulo DEPTH. An extra bit distinguishes full from empty.
- src==dst (e.g. R3→R3) is legal and issued normally.
- dst_in is never multi-hot. bus_sel is stable across the DRIVE and LATCH cycles of a transfer.
- busy = (FIFO non-empty) | (state≠IDLE).

Test Plan:
- Reset then one command src=5 dst=2 at cycle 0 → bus_sel=5, bus_sel_valid=1 in cycles 2–3; dst_in=0x000004 only in cycle 3; xfer_count=1; busy low from cycle 4.
- Back-to-back commands (21→21 MDR→IR, 20→18 PC→PC, 19→22 ZLow→Y) with cmd_valid held → cmd_ready drops after 2 are queued; strobes dst_in=0x200000, 0x040000, 0x400000 at 2-cycle spacing, in order; xfer_count=3.
- Invalid command src=25 dst=1, followed by valid 16→0 → err_pulse=1 for one cycle, no dst_in strobe for the bad entry; HI→R0 completes with dst_in=0x000001; xfer_count=1.
- SETTLE=3, command 0→23 → bus_sel_valid high for 4 cycles; dst_in=0x800000 only in the last of them.
- Assert clr during the DRIVE cycle of 7→4 → all outputs 0 immediately; no dst_in strobe; FIFO empty; cmd_ready=1.
- Preload xfer_count to 0xFFFF via 65535 transfers, then one more → xfer_count=0x0000.
